uart_tx_buffered: RTL

UART transmitter: serialises 8-bit bytes as 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity) on a single serial line. It is the transmit counterpart of the existing UART receiver and shares the same baud parameterisation. A small input FIFO lets upstream logic queue several bytes with a valid/ready handshake, so frames go out back-to-back without per-byte polling.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_fifo.sv | 67 ++++++
 rtl/uart_tx_buffered.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings and frame constants used by the
// transmitter and, later, the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } uart_state_t;

  localparam int   FRAME_DATA_BITS = 8;
  localparam int   CLK_CNT_W       = 12;
  localparam logic IDLE_LEVEL      = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter. Full/empty come from
// the occupancy count; ready is registered from the next-state count.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = FRAME_DATA_BITS,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              ready
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              ready_q;
  logic              full;
  logic              push_ok;
  logic              pop_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];
  assign count    = count_q;
  assign ready    = ready_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_d;
      ready_q <= (count_d < CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO front end plus frame FSM and shifter.
//
// state   | meaning
// IDLE    | line high; pops the next queued byte when one is available
// START   | start bit (line low) for CLKS_PER_BIT cycles
// DATA    | eight data bits, LSB first, CLKS_PER_BIT cycles each
// STOP    | stop bit (line high); Done pulses as it ends
// CLEANUP | one settling cycle before returning to IDLE
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = 3603,
  parameter  int FIFO_DEPTH   = 4,
  localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             i_Clock,
  input  logic             i_Reset_n,
  input  logic             i_Tx_DV,
  input  logic [7:0]       i_Tx_Byte,
  output logic             o_Tx_Ready,
  output logic             o_Tx_Serial,
  output logic             o_Tx_Active,
  output logic             o_Tx_Done,
  output logic [CNT_W-1:0] o_Fifo_Count
);

  localparam logic [CLK_CNT_W-1:0] BIT_END  = CLK_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]           LAST_BIT = 3'(FRAME_DATA_BITS - 1);

  uart_state_t          state_q, state_d;
  logic [CLK_CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic                 serial_q, serial_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;
  logic                 avail_q;
  logic                 pop;
  logic [7:0]           fifo_data;
  logic                 fifo_empty;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(FRAME_DATA_BITS)) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .push      (i_Tx_DV),
    .push_data (i_Tx_Byte),
    .pop       (pop),
    .pop_data  (fifo_data),
    .count     (o_Fifo_Count),
    .empty     (fifo_empty),
    .ready     (o_Tx_Ready)
  );

  // Pop decision uses a registered copy of non-empty, so a freshly written
  // byte leaves two edges after it was accepted.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) avail_q <= 1'b0;
    else            avail_q <= !fifo_empty;
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    serial_d  = serial_q;
    active_d  = active_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        serial_d  = IDLE_LEVEL;
        active_d  = 1'b0;
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (avail_q && !fifo_empty) begin
          pop      = 1'b1;
          shift_d  = fifo_data;
          serial_d = 1'b0;
          active_d = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        if (clk_cnt_q == BIT_END) begin
          serial_d  = shift_q[0];
          bit_idx_d = '0;
          clk_cnt_d = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_CNT_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt_q == BIT_END) begin
          clk_cnt_d = '0;
          if (bit_idx_q < LAST_BIT) begin
            bit_idx_d = bit_idx_q + 3'd1;
            serial_d  = shift_q[bit_idx_q + 3'd1];
          end else begin
            serial_d = IDLE_LEVEL;
            state_d  = STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_CNT_W'(1);
        end
      end
      STOP: begin
        if (clk_cnt_q == BIT_END) begin
          clk_cnt_d = '0;
          done_d    = 1'b1;
          active_d  = 1'b0;
          state_d   = CLEANUP;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_CNT_W'(1);
        end
      end
      CLEANUP: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        serial_d = IDLE_LEVEL;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= IDLE_LEVEL;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;

endmodule
